// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: a small array of 32-bit software-writable registers
// exported to user logic.
//
// Ports:
//   OPB_Clk, OPB_Rst_n   clock and asynchronous active-low reset
//   OPB_ABus/BE/DBus     address, byte enables (BE[0] -> DBus[0:7]), write data
//   OPB_RNW/select       read-not-write and transfer select (OPB_seqAddr ignored)
//   Sl_DBus              read data, zero outside a read acknowledge
//   Sl_xferAck/errAck    one-cycle acknowledge / error acknowledge
//   Sl_retry/toutSup     tied low
//   user_data_out        register k on bits [32k+31:32k]
//   user_wr_strobe       one-cycle pulse per register when written
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0]           C_BASEADDR   = 32'h0100_0500,
  parameter logic [31:0]           C_HIGHADDR   = 32'h0100_05FF,
  parameter int unsigned           C_NUM_REGS   = 4,
  parameter logic [C_NUM_REGS-1:0] C_PULSE_MASK = '0,
  parameter logic [31:0]           C_RESET_VAL  = 32'h0
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0] user_data_out,
  output logic [C_NUM_REGS-1:0]   user_wr_strobe
);

  typedef enum logic [1:0] {StIdle, StAck, StHold} state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q;
  logic        err_q, rnw_q;
  logic [31:0] regs_q [C_NUM_REGS];
  logic [31:0] regs_d [C_NUM_REGS];

  // Descending-order views of the big-endian bus: be[3] == OPB_BE[0] covers dbus[31:24].
  logic [31:0] abus, dbus, offset, rd_data;
  logic [3:0]  be;
  logic        hit, in_ack, wr_en;
  logic        unused_bits;

  assign abus   = OPB_ABus;
  assign dbus   = OPB_DBus;
  assign be     = OPB_BE;
  assign offset = abus - C_BASEADDR;
  assign hit    = OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

  assign unused_bits = ^{OPB_seqAddr, offset[1:0]};

  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hit) state_d = StAck;
      StAck:   state_d = OPB_select ? StHold : StIdle;
      StHold:  if (!OPB_select) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rnw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Capture the decode once, on the select cycle of a hit.
      if (state_q == StIdle && hit) begin
        idx_q <= offset[5:2];
        err_q <= (offset[31:2] >= 30'(C_NUM_REGS));
        rnw_q <= OPB_RNW;
      end
    end
  end

  always_comb begin
    // A master dropping select during StAck aborts the transfer silently.
    in_ack         = (state_q == StAck) && OPB_select;
    Sl_xferAck     = in_ack && !err_q;
    Sl_errAck      = in_ack && err_q;
    wr_en          = Sl_xferAck && !rnw_q;
    rd_data        = '0;
    user_wr_strobe = '0;
    for (int k = 0; k < int'(C_NUM_REGS); k++) begin
      if (idx_q == 4'(k)) begin
        rd_data           = regs_q[k];
        user_wr_strobe[k] = wr_en;
      end
    end
    Sl_DBus = (Sl_xferAck && rnw_q) ? rd_data : '0;

    for (int k = 0; k < int'(C_NUM_REGS); k++) begin
      // Self-clearing registers fall back to the reset value the cycle after any write.
      regs_d[k] = C_PULSE_MASK[k] ? C_RESET_VAL : regs_q[k];
      if (user_wr_strobe[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) regs_d[k][8*b +: 8] = dbus[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int k = 0; k < int'(C_NUM_REGS); k++) regs_q[k] <= C_RESET_VAL;
    end else begin
      for (int k = 0; k < int'(C_NUM_REGS); k++) regs_q[k] <= regs_d[k];
    end
  end

  always_comb begin
    user_data_out = '0;
    for (int k = 0; k < int'(C_NUM_REGS); k++) user_data_out[32*k +: 32] = regs_q[k];
  end

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench for opb_register_bank_ppc2simulink: directed scenarios plus
// random transfers, with a queue of expected acknowledges consumed by a monitor.
module tb_opb_register_bank_ppc2simulink;

  localparam logic [31:0] BASE  = 32'h0100_0500;
  localparam logic [31:0] HIGH  = 32'h0100_05FF;
  localparam int          NUM   = 4;
  localparam logic [3:0]  PULSE = 4'b1000;
  localparam logic [31:0] RVAL  = 32'h5A5A_C3C3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [0:31]     abus = '0;
  logic [0:3]      be_bus = '0;
  logic [0:31]     dbus = '0;
  logic            rnw = 1'b0, sel = 1'b0, seq = 1'b0;
  logic [0:31]     sl_dbus;
  logic            xfer_ack, err_ack, retry, tout_sup;
  logic [NUM*32-1:0] udo;
  logic [NUM-1:0]  strobe;

  opb_register_bank_ppc2simulink #(
    .C_BASEADDR  (BASE),
    .C_HIGHADDR  (HIGH),
    .C_NUM_REGS  (NUM),
    .C_PULSE_MASK(PULSE),
    .C_RESET_VAL (RVAL)
  ) dut (
    .OPB_Clk       (clk),
    .OPB_Rst_n     (rst_n),
    .OPB_ABus      (abus),
    .OPB_BE        (be_bus),
    .OPB_DBus      (dbus),
    .OPB_RNW       (rnw),
    .OPB_select    (sel),
    .OPB_seqAddr   (seq),
    .Sl_DBus       (sl_dbus),
    .Sl_xferAck    (xfer_ack),
    .Sl_errAck     (err_ack),
    .Sl_retry      (retry),
    .Sl_toutSup    (tout_sup),
    .user_data_out (udo),
    .user_wr_strobe(strobe)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [NUM];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Monitor: every acknowledge must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (xfer_ack && err_ack) chk("both_acks", 1, 0);
    if (xfer_ack || err_ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_kind", {127'd0, err_ack}, {127'd0, e.err});
        chk("rd_data", {96'd0, sl_dbus}, {96'd0, e.data});
        chk("wr_strobe", {124'd0, strobe}, {124'd0, e.strb});
      end
    end else begin
      chk("idle_outputs", {90'd0, sl_dbus, strobe, retry, tout_sup}, '0);
    end
  end

  task automatic check_model(input string name);
    logic [NUM*32-1:0] v;
    for (int k = 0; k < NUM; k++) v[32*k +: 32] = model[k];
    chk(name, udo, v);
  endtask

  task automatic xfer(input logic [31:0] addr, input bit rd, input logic [31:0] data,
                      input logic [3:0] be, input int hold);
    bit          in_rng, got, is_wr;
    int          idx;
    exp_t        e;
    logic [31:0] mask, newv;
    in_rng = (addr >= BASE) && (addr <= HIGH);
    idx    = int'((addr - BASE) >> 2);
    mask   = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    is_wr  = 1'b0;
    newv   = '0;
    if (in_rng) begin
      e.err = 1'b0; e.data = '0; e.strb = '0;
      if (idx >= NUM) begin
        e.err = 1'b1;
      end else if (rd) begin
        e.data = model[idx];
      end else begin
        is_wr  = 1'b1;
        e.strb = 4'(1 << idx);
        newv   = (model[idx] & ~mask) | (data & mask);
        if (!PULSE[idx]) model[idx] = newv;
      end
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    abus = addr; rnw = rd; dbus = data; be_bus = be; sel = 1'b1;
    if (!in_rng) begin
      repeat (2) begin @(posedge clk); #1; end
      sel = 1'b0;
      @(negedge clk);
      check_model("out_of_range_no_change");
      return;
    end
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      got = xfer_ack | err_ack;
    end
    if (!got) begin
      chk("ack_timeout", 0, 1);
      exp_q.delete();
      sel = 1'b0;
      return;
    end
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk); #1;
      if (h == hold) sel = 1'b0;
      @(negedge clk);
      if (h == 0 && is_wr) chk("wr_visible", {96'd0, udo[idx*32 +: 32]}, {96'd0, newv});
    end
    @(negedge clk);
    check_model("user_data_out");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NUM; k++) model[k] = RVAL;
    repeat (3) @(negedge clk);
    check_model("reset_regs");
    rst_n = 1'b1;

    xfer(32'h0100_0504, 1'b0, 32'hDEAD_BEEF, 4'b1111, 0);
    xfer(32'h0100_0500, 1'b0, 32'h0000_0000, 4'b1111, 0);
    xfer(32'h0100_0500, 1'b0, 32'h1122_3344, 4'b0100, 0);
    xfer(32'h0100_0500, 1'b1, 32'h0, 4'b1111, 0);
    chk("partial_byte_write", {96'd0, model[0]}, {96'd0, 32'h0022_0000});
    xfer(32'h0100_0510, 1'b1, 32'h0, 4'b1111, 0);
    xfer(32'h0100_050C, 1'b0, 32'h0000_0001, 4'b1111, 0);
    xfer(32'h0100_050C, 1'b1, 32'h0, 4'b1111, 0);
    xfer(32'h0100_0600, 1'b0, 32'hFFFF_FFFF, 4'b1111, 0);
    xfer(32'h0100_04FC, 1'b0, 32'hFFFF_FFFF, 4'b1111, 0);
    xfer(32'h0100_0508, 1'b1, 32'h0, 4'b1111, 1);

    // Select dropped during the acknowledge cycle: no ack, no write.
    @(posedge clk); #1;
    abus = 32'h0100_0508; rnw = 1'b0; dbus = 32'h1234_5678; be_bus = 4'b1111; sel = 1'b1;
    @(posedge clk); #1;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    check_model("abort_no_write");

    // Reset asserted in the acknowledge cycle.
    @(posedge clk); #1;
    abus = 32'h0100_0508; rnw = 1'b0; dbus = 32'hCAFE_F00D; be_bus = 4'b1111; sel = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; sel = 1'b0;
    for (int k = 0; k < NUM; k++) model[k] = RVAL;
    repeat (2) @(negedge clk);
    check_model("reset_mid_ack");
    rst_n = 1'b1;
    xfer(32'h0100_0504, 1'b1, 32'h0, 4'b1111, 0);

    for (int i = 0; i < 60; i++) begin
      int          kind;
      logic [31:0] a;
      kind = int'($urandom_range(0, 9));
      if (kind <= 5)      a = BASE + 32'($urandom_range(0, NUM - 1)) * 4 + 32'($urandom_range(0, 3));
      else if (kind <= 7) a = BASE + 32'($urandom_range(NUM, 63)) * 4;
      else if (kind == 8) a = HIGH + 32'($urandom_range(1, 64));
      else                a = BASE - 32'($urandom_range(1, 64));
      xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           int'($urandom_range(0, 2)));
    end

    repeat (4) @(negedge clk);
    chk("pending_acks", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
